game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_game_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game/shot clock sequencer with score request arbitration
module game_sequencer #(
  parameter int SHOT_FULL   = 24,
  parameter int SHOT_SHORT  = 14,
  parameter int PERIOD_SECS = 600,
  parameter int NUM_PERIODS = 4,
  parameter int BUZZ_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic [2:0] btn_points,
  input  logic       team_sel,
  input  logic       sub_mode,
  input  logic       btn_reload24,
  input  logic       btn_reload14,
  input  logic [6:0] score_t1,
  input  logic [6:0] score_t2,
  output logic       score_we_t1,
  output logic       score_we_t2,
  output logic [1:0] score_delta,
  output logic       score_sub,
  output logic       score_reject,
  output logic [4:0] shot_clock,
  output logic [9:0] game_secs,
  output logic [2:0] period,
  output logic       running,
  output logic       buzzer
);

  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [4:0]    FULL_V      = 5'(SHOT_FULL);
  localparam logic [4:0]    SHORT_V     = 5'(SHOT_SHORT);
  localparam logic [9:0]    PERIOD_V    = 10'(PERIOD_SECS);
  localparam logic [2:0]    LAST_PERIOD = 3'(NUM_PERIODS);
  localparam logic [BW-1:0] BUZZ_LOAD   = BW'(BUZZ_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, SHOT_OUT, PERIOD_END, GAME_OVER} state_t;
  state_t state;

  logic          primed, prevStart, prevReload24, prevReload14;
  logic [2:0]    prevPoints;
  logic          startEdge, reload24Edge, reload14Edge, reloadEdge;
  logic [2:0]    pointsEdge;
  logic [4:0]    reloadValue, reloadLoad;
  logic [9:0]    reloadLimit;
  logic [BW-1:0] buzzCount;

  logic          reqValid, reqTeam, reqSub, reqBad, scoreOpen;
  logic [1:0]    reqDelta;
  logic [6:0]    selScore;
  logic [7:0]    addSum;

  // primed stays low for the first cycle after reset so held buttons only seed the history
  assign startEdge    = primed & btn_start & ~prevStart;
  assign reload24Edge = primed & btn_reload24 & ~prevReload24;
  assign reload14Edge = primed & btn_reload14 & ~prevReload14;
  assign reloadEdge   = reload24Edge | reload14Edge;
  assign pointsEdge   = {3{primed}} & btn_points & ~prevPoints;

  assign reloadValue = reload24Edge ? FULL_V : SHORT_V;
  // On a RUN tick the reload is bounded by the game clock it is about to show
  assign reloadLimit = (state == RUN && tick && game_secs != 10'd0) ? game_secs - 10'd1 : game_secs;
  assign reloadLoad  = ({5'd0, reloadValue} > reloadLimit) ? reloadLimit[4:0] : reloadValue;

  assign scoreOpen = (state == RUN) || (state == PAUSE) || (state == SHOT_OUT) || (state == PERIOD_END);
  assign selScore  = reqTeam ? score_t2 : score_t1;
  assign addSum    = {1'b0, selScore} + {6'd0, reqDelta};
  assign reqBad    = reqSub ? (selScore < {5'd0, reqDelta}) : (addSum > 8'd99);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      primed       <= 1'b0;
      prevStart    <= 1'b0;
      prevReload24 <= 1'b0;
      prevReload14 <= 1'b0;
      prevPoints   <= 3'b000;
    end else begin
      primed       <= 1'b1;
      prevStart    <= btn_start;
      prevReload24 <= btn_reload24;
      prevReload14 <= btn_reload14;
      prevPoints   <= btn_points;
    end
  end

  // Request is captured on the edge cycle and judged against the score register one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reqValid     <= 1'b0;
      reqTeam      <= 1'b0;
      reqSub       <= 1'b0;
      reqDelta     <= 2'd0;
      score_we_t1  <= 1'b0;
      score_we_t2  <= 1'b0;
      score_reject <= 1'b0;
      score_delta  <= 2'd0;
      score_sub    <= 1'b0;
    end else begin
      reqValid     <= scoreOpen && (pointsEdge != 3'b000);
      reqTeam      <= team_sel;
      reqSub       <= sub_mode;
      reqDelta     <= pointsEdge[2] ? 2'd3 : (pointsEdge[1] ? 2'd2 : 2'd1);
      score_we_t1  <= reqValid & ~reqBad & ~reqTeam;
      score_we_t2  <= reqValid & ~reqBad & reqTeam;
      score_reject <= reqValid & reqBad;
      if (reqValid) begin
        score_delta <= reqDelta;
        score_sub   <= reqSub;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shot_clock <= FULL_V;
      game_secs  <= PERIOD_V;
      period     <= 3'd1;
      running    <= 1'b0;
      buzzer     <= 1'b0;
      buzzCount  <= '0;
    end else begin
      if (buzzCount != '0) buzzCount <= buzzCount - BW'(1);
      else                 buzzer    <= 1'b0;
      case (state)
        IDLE: if (startEdge) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: begin
          if (tick) begin
            game_secs <= (game_secs != 10'd0) ? game_secs - 10'd1 : 10'd0;
            if (reloadEdge)               shot_clock <= reloadLoad;
            else if (shot_clock != 5'd0)  shot_clock <= shot_clock - 5'd1;
            if (game_secs <= 10'd1) begin
              state     <= (period < LAST_PERIOD) ? PERIOD_END : GAME_OVER;
              running   <= 1'b0;
              buzzer    <= 1'b1;
              buzzCount <= BUZZ_LOAD;
            end else if (!reloadEdge && shot_clock <= 5'd1) begin
              state     <= SHOT_OUT;
              running   <= 1'b0;
              buzzer    <= 1'b1;
              buzzCount <= BUZZ_LOAD;
            end else if (startEdge) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end else begin
            if (reloadEdge) shot_clock <= reloadLoad;
            if (startEdge) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (reloadEdge) shot_clock <= reloadLoad;
          if (startEdge) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        SHOT_OUT: begin
          if (reloadEdge) shot_clock <= reloadLoad;
          // a non-zero shot clock here can only come from a reload
          if (startEdge && shot_clock != 5'd0) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        PERIOD_END: if (startEdge) begin
          state      <= RUN;
          running    <= 1'b1;
          period     <= period + 3'd1;
          game_secs  <= PERIOD_V;
          shot_clock <= FULL_V;
        end
        GAME_OVER: ;
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer against a rule-level model
module tb_game_sequencer;

  localparam int SF = 24, SS = 14, PS = 600, NP = 4, BC = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SHOT = 3, M_PEND = 4, M_OVER = 5;

  logic       clock, reset, tick, btn_start, team_sel, sub_mode, btn_reload24, btn_reload14;
  logic [2:0] btn_points;
  logic [6:0] score_t1, score_t2;
  logic       score_we_t1, score_we_t2, score_sub, score_reject, running, buzzer;
  logic [1:0] score_delta;
  logic [4:0] shot_clock;
  logic [9:0] game_secs;
  logic [2:0] period;

  game_sequencer #(.SHOT_FULL(SF), .SHOT_SHORT(SS), .PERIOD_SECS(PS),
                   .NUM_PERIODS(NP), .BUZZ_CYCLES(BC)) dut (
    .clock(clock), .reset(reset), .tick(tick), .btn_start(btn_start),
    .btn_points(btn_points), .team_sel(team_sel), .sub_mode(sub_mode),
    .btn_reload24(btn_reload24), .btn_reload14(btn_reload14),
    .score_t1(score_t1), .score_t2(score_t2),
    .score_we_t1(score_we_t1), .score_we_t2(score_we_t2),
    .score_delta(score_delta), .score_sub(score_sub), .score_reject(score_reject),
    .shot_clock(shot_clock), .game_secs(game_secs), .period(period),
    .running(running), .buzzer(buzzer)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nCmp = 0, nErr = 0;
  bit checkEn = 0;

  int mMode, mShot, mGame, mPeriod, mBuzz, mDelta;
  bit mArm, mWe1, mWe2, mRej, mSub, pendV, pendTeam, pendSub;
  int pendDelta;
  logic pStart, pR24, pR14;
  logic [2:0] pPts;
  logic sRej, sWe1, sWe2, sSub;
  logic [1:0] sDelta;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mShot = SF; mGame = PS; mPeriod = 1; mBuzz = 0;
    mArm = 0; pStart = 0; pR24 = 0; pR14 = 0; pPts = 3'b000;
    pendV = 0; pendTeam = 0; pendSub = 0; pendDelta = 0;
    mWe1 = 0; mWe2 = 0; mRej = 0; mDelta = 0; mSub = 0;
  endtask

  task automatic modelStep();
    bit eS, e24, e14, reload, enter;
    logic [2:0] eP;
    int sc, res, val, g;
    eS  = mArm && btn_start && !pStart;
    e24 = mArm && btn_reload24 && !pR24;
    e14 = mArm && btn_reload14 && !pR14;
    eP  = mArm ? (btn_points & ~pPts) : 3'b000;
    pStart = btn_start; pR24 = btn_reload24; pR14 = btn_reload14; pPts = btn_points; mArm = 1;
    mWe1 = 0; mWe2 = 0; mRej = 0;
    if (pendV) begin
      sc  = pendTeam ? int'(score_t2) : int'(score_t1);
      res = pendSub ? sc - pendDelta : sc + pendDelta;
      if (res < 0 || res > 99) mRej = 1;
      else if (pendTeam)       mWe2 = 1;
      else                     mWe1 = 1;
      mDelta = pendDelta; mSub = pendSub;
    end
    pendV = 0;
    if (eP != 3'b000 && (mMode == M_RUN || mMode == M_PAUSE || mMode == M_SHOT || mMode == M_PEND)) begin
      pendV = 1; pendTeam = team_sel; pendSub = sub_mode;
      pendDelta = eP[2] ? 3 : (eP[1] ? 2 : 1);
    end
    enter = 0;
    reload = e24 || e14;
    val = e24 ? SF : SS;
    case (mMode)
      M_IDLE: if (eS) mMode = M_RUN;
      M_RUN: begin
        if (tick) begin
          g = (mGame > 0) ? mGame - 1 : 0;
          mShot = reload ? imin(val, g) : ((mShot > 0) ? mShot - 1 : 0);
          mGame = g;
          if (g == 0) begin mMode = (mPeriod < NP) ? M_PEND : M_OVER; enter = 1; end
          else if (mShot == 0) begin mMode = M_SHOT; enter = 1; end
          else if (eS) mMode = M_PAUSE;
        end else begin
          if (reload) mShot = imin(val, mGame);
          if (eS) mMode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (reload) mShot = imin(val, mGame);
        if (eS) mMode = M_RUN;
      end
      M_SHOT: begin
        if (eS && mShot > 0) mMode = M_RUN;
        if (reload) mShot = imin(val, mGame);
      end
      M_PEND: if (eS) begin
        mPeriod++; mGame = PS; mShot = SF; mMode = M_RUN;
      end
      default: ;
    endcase
    if (enter) mBuzz = BC;
    else if (mBuzz > 0) mBuzz--;
  endtask

  task automatic cyc(input bit tk);
    tick = tk;
    @(posedge clock);
    if (reset) modelReset();
    else modelStep();
    @(negedge clock);
    tick = 1'b0;
  endtask

  always @(negedge clock) begin : compare
    logic [25:0] e, a;
    if (checkEn) begin
      e = {mWe1, mWe2, mRej, 2'(mDelta), mSub, (mMode == M_RUN), (mBuzz > 0),
           5'(mShot), 10'(mGame), 3'(mPeriod)};
      a = {score_we_t1, score_we_t2, score_reject, score_delta, score_sub, running, buzzer,
           shot_clock, game_secs, period};
      nCmp++;
      if (a !== e) begin
        nErr++;
        $display("FAIL outputs @%0t: got we1=%b we2=%b rej=%b d=%0d sub=%b run=%b buzz=%b shot=%0d game=%0d per=%0d; expected we1=%b we2=%b rej=%b d=%0d sub=%b run=%b buzz=%b shot=%0d game=%0d per=%0d",
                 $time, a[25], a[24], a[23], a[22:21], a[20], a[19], a[18], a[17:13], a[12:3], a[2:0],
                 e[25], e[24], e[23], e[22:21], e[20], e[19], e[18], e[17:13], e[12:3], e[2:0]);
      end
    end
  end

  task automatic pressStart();
    btn_start = 1'b1; cyc(0);
    btn_start = 1'b0; cyc(0);
  endtask

  task automatic pressReload(input bit r24, input bit r14);
    btn_reload24 = r24; btn_reload14 = r14; cyc(0);
    btn_reload24 = 1'b0; btn_reload14 = 1'b0; cyc(0);
  endtask

  task automatic pressPoints(input logic [2:0] b);
    btn_points = b; cyc(0); cyc(0);
    sRej = score_reject; sWe1 = score_we_t1; sWe2 = score_we_t2; sDelta = score_delta; sSub = score_sub;
    btn_points = 3'b000; cyc(0); cyc(0);
  endtask

  task automatic runTicks(input int target);
    int n;
    n = 0;
    while (n < 4000 && mMode == M_RUN && mGame != target) begin
      if (mShot <= 3 && mGame > mShot) pressReload(1'b1, 1'b0);
      else begin cyc(1); cyc(0); end
      n++;
    end
    if (n >= 4000) begin
      nCmp++; nErr++;
      $display("FAIL runTicks: iteration bound expired in mode %0d", mMode);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    reset = 1'b1; tick = 1'b0; btn_start = 1'b1; btn_points = 3'b000; team_sel = 1'b0;
    sub_mode = 1'b0; btn_reload24 = 1'b0; btn_reload14 = 1'b0; score_t1 = 7'd0; score_t2 = 7'd0;
    modelReset();
    #1 checkEn = 1;
    repeat (3) cyc(0);
    check("reset shot_clock", shot_clock, 24);
    check("reset game_secs", game_secs, 600);
    check("reset period", period, 1);
    check("reset running", running, 0);
    check("reset buzzer", buzzer, 0);

    reset = 1'b0;
    repeat (3) cyc(0);
    check("held start ignored", running, 0);
    btn_start = 1'b0; cyc(0);
    pressPoints(3'b001);
    check("idle points reject", sRej, 0);
    check("idle points strobe", sWe1, 0);
    pressStart();
    check("start runs", running, 1);

    for (int i = 1; i <= 24; i++) begin
      cyc(1);
      check("shot countdown", shot_clock, 24 - i);
      if (i < 24) cyc(0);
    end
    check("shot out running", running, 0);
    check("shot out game_secs", game_secs, 576);
    hi = int'(buzzer);
    for (int i = 0; i < 11; i++) begin
      cyc(0);
      hi += int'(buzzer);
    end
    check("shot out buzzer cycles", hi, 8);

    pressStart();
    check("start without reload ignored", running, 0);

    team_sel = 1'b1; sub_mode = 1'b0; score_t2 = 7'd98;
    pressPoints(3'b110);
    check("t2 98+3 reject", sRej, 1);
    check("t2 98+3 no strobe", sWe2, 0);
    score_t2 = 7'd96;
    pressPoints(3'b110);
    check("t2 96+3 strobe", sWe2, 1);
    check("t2 96+3 no reject", sRej, 0);
    check("t2 96+3 delta", sDelta, 3);
    team_sel = 1'b0; sub_mode = 1'b1; score_t1 = 7'd1;
    pressPoints(3'b010);
    check("t1 1-2 reject", sRej, 1);
    pressPoints(3'b001);
    check("t1 1-1 strobe", sWe1, 1);
    check("t1 1-1 delta", sDelta, 1);
    check("t1 1-1 sub", sSub, 1);
    sub_mode = 1'b0; score_t1 = 7'd50;
    pressPoints(3'b011);
    check("priority 2 over 1", sDelta, 2);

    pressReload(1'b1, 1'b0);
    check("reload24 in shot out", shot_clock, 24);
    pressStart();
    check("resume after reload", running, 1);
    pressStart();
    check("pause", running, 0);
    cyc(1);
    check("pause tick shot", shot_clock, 24);
    check("pause tick game", game_secs, 576);
    cyc(0);
    pressStart();
    pressReload(1'b0, 1'b1);
    check("reload14", shot_clock, 14);
    btn_reload24 = 1'b1; btn_reload14 = 1'b1;
    cyc(1);
    check("both reload with tick shot", shot_clock, 24);
    check("both reload with tick game", game_secs, 575);
    btn_reload24 = 1'b0; btn_reload14 = 1'b0;
    cyc(0);

    runTicks(10);
    pressReload(1'b1, 1'b0);
    check("reload clamped to game", shot_clock, 10);
    repeat (9) begin cyc(1); cyc(0); end
    check("pre end game", game_secs, 1);
    check("pre end shot", shot_clock, 1);
    cyc(1);
    check("period end buzzer", buzzer, 1);
    check("period end running", running, 0);
    check("period end game", game_secs, 0);
    cyc(0);
    pressStart();
    check("next period running", running, 1);
    check("next period number", period, 2);
    check("next period game", game_secs, 600);
    check("next period shot", shot_clock, 24);

    for (int p = 0; p < 6 && mMode != M_OVER; p++) begin
      if (mMode == M_PEND) pressStart();
      runTicks(-1);
    end
    check("game over period", period, 4);
    check("game over game", game_secs, 0);
    check("game over running", running, 0);
    check("game over buzzer", buzzer, 1);
    btn_start = 1'b1; btn_points = 3'b100;
    cyc(0); cyc(0); cyc(0);
    check("game over start ignored", running, 0);
    check("game over points reject", score_reject, 0);
    check("game over points strobe", score_we_t1, 0);
    check("game over buzzer still on", buzzer, 1);

    #2 reset = 1'b1;
    modelReset();
    #1;
    check("async reset buzzer", buzzer, 0);
    check("async reset running", running, 0);
    check("async reset period", period, 1);
    check("async reset shot", shot_clock, 24);
    btn_start = 1'b0; btn_points = 3'b000;
    cyc(0); cyc(0);
    reset = 1'b0;
    cyc(0); cyc(0);
    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
    $finish;
  end

endmodule
